dbus_sram_responder: RTL
========================

// Module: dbus_sram_responder
// PURPOSE
//   Memory-side responder for the CPU data bus: answers the pipeline's d_valid requests with a
//   data_ok pulse after a fixed latency.
//   The pipeline holds stall_e/stall_m while d_valid & ~d_data_ok, so this block sets the
//   data-side stall length.
//   Backed by a word-addressed synchronous array; used in simulation tops and FPGA bring-up in
//   place of the cache/AXI path.
// PARAMETERS
//   LATENCY    2    cycles from request acceptance to data_ok; legal range 1..15
//   ADDR_BITS  12   word-index width; array depth = 2**ADDR_BITS words of 32 bits
// PORTS
//   clk         in   1   clock, all state on rising edge
//   reset       in   1   synchronous, active-high
//   dreq_valid  in   1   request present; CPU holds it and all dreq_* stable until data_ok
//   dreq_addr   in   32  byte address; word index = dreq_addr[ADDR_BITS+1:2], upper bits ignored
//   dreq_size   in   3   msize: 0=byte, 1=half, 2=word
//   dreq_strobe in   4   byte write enables; 4'b0 = read
//   dreq_wdata  in   32  write data, byte lanes already aligned by the CPU
//   dresp_addr_ok out 1  one-cycle pulse when the request is accepted
//   dresp_data_ok out 1  one-cycle pulse when the response is complete
//   dresp_rdata  out  32 full read word; valid only while data_ok=1, else 0
//   dresp_err    out  1  pulses with data_ok if the access was misaligned
//   perf_wait   out  32  saturating count of cycles with dreq_valid=1 and data_ok=0
// BEHAVIOUR
//   States: IDLE, WAIT, RESP. Reset -> IDLE, cnt=0, perf_wait=0, all resp outputs 0.
//   IDLE: dreq_valid=1 -> latch addr/size/strobe/wdata, addr_ok=1 this cycle, cnt=LATENCY-1,
//     go to WAIT, or go directly to RESP if LATENCY=1.
//   WAIT: while dreq_valid=1, cnt decrements each cycle; at cnt=0 go to RESP.
//     If dreq_valid drops in WAIT, abort: go to IDLE, no write, no data_ok.
//   RESP (one cycle): data_ok=1 and rdata=array[word index].
//     Write: bytes with strobe[i]=1 are updated at the end of this cycle.
//     rdata returns the pre-write word. Next state is IDLE.
//   Latency: request seen in cycle T -> data_ok in cycle T+LATENCY exactly.
//   Back-to-back: a new request is accepted at the earliest in cycle T+LATENCY+1.
//     The CPU changes dreq_* in the cycle after data_ok.
//   Misaligned access: size=1 with addr[0]=1, or size=2 with addr[1:0]!=0.
//     Write is suppressed, rdata=0, err=1 with data_ok, same latency.
//   size>2 is treated as misaligned.
//   Array contents are not cleared by reset.
//   Reset asserted in WAIT/RESP -> IDLE next cycle; no data_ok, no write.
//   perf_wait saturates at 32'hFFFF_FFFF and does not wrap.
// TESTING
//   LATENCY=2, write addr 0x10, strobe 4'hF, wdata 0xDEADBEEF
//     -> addr_ok in cycle T, data_ok in cycle T+2; then read 0x10 -> rdata 0xDEADBEEF.
//   Partial write: word 0x20 holds 0x11223344; write strobe 4'b0010, wdata 0x0000AA00
//     -> reading back gives 0x1122AA44.
//   Misaligned: word read at 0x22 -> data_ok at T+2, err=1, rdata=0, memory unchanged.
//   Abort: drop dreq_valid one cycle after accept (LATENCY=3)
//     -> no data_ok; the next request still completes in exactly 3 cycles.
//   Reset in WAIT of a write -> state IDLE, data_ok never pulses, target word unchanged.
//   Back-to-back: 4 reads with LATENCY=1
//     -> data_ok every 2nd cycle; perf_wait increments by 1 per request.

Source files
------------

// File: rtl/dbus_sram_responder_if.sv
// CPU data-bus request/response bundle between the pipeline and its memory responder.
interface dbus_sram_responder_if;
  logic        dreq_valid;
  logic [31:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_wdata;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [31:0] dresp_rdata;
  logic        dresp_err;

  modport master (
    output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_wdata,
    input  dresp_addr_ok, dresp_data_ok, dresp_rdata, dresp_err
  );

  modport slave (
    input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_wdata,
    output dresp_addr_ok, dresp_data_ok, dresp_rdata, dresp_err
  );
endinterface

// File: rtl/dbus_sram_responder.sv
// Fixed-latency word-addressed SRAM responder for the CPU data bus.
// Accepts one request at a time, answers with a data_ok pulse LATENCY cycles
// after acceptance, and counts the cycles the pipeline spends waiting.
module dbus_sram_responder #(
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned ADDR_BITS = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  dbus_sram_responder_if.slave  dbus,
  output logic [31:0]           perf_wait
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 accept;
  logic                 misaligned_in;
  logic                 resp_active;
  logic                 write_en;

  logic [ADDR_BITS-1:0] idx_q;
  logic [3:0]           strobe_q;
  logic [31:0]          wdata_q;
  logic                 misaligned_q;

  logic [31:0]          mem [2**ADDR_BITS];
  logic [31:0]          rd_q;
  logic [ADDR_BITS-1:0] rd_idx;

  // Address bits above the word index do not select anything.
  logic unused_addr_bits;
  assign unused_addr_bits = ^dbus.dreq_addr[31:ADDR_BITS+2];

  // Alignment check for the incoming request; unknown sizes count as misaligned.
  always_comb begin
    misaligned_in = 1'b1;
    case (dbus.dreq_size)
      3'd0:    misaligned_in = 1'b0;
      3'd1:    misaligned_in = dbus.dreq_addr[0];
      3'd2:    misaligned_in = (dbus.dreq_addr[1:0] != 2'b00);
      default: misaligned_in = 1'b1;
    endcase
  end

  // FSM state and latency counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. The counter is loaded with LATENCY-1 on accept and the
  // FSM moves to RESP on the decrement that takes it to zero, so RESP lands
  // exactly LATENCY cycles after the accept cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dbus.dreq_valid) begin
          accept  = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!dbus.dreq_valid) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Capture the request on acceptance; the CPU keeps it stable anyway, but the
  // latched copy decouples the write from the bus.
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q        <= dbus.dreq_addr[ADDR_BITS+1:2];
      strobe_q     <= dbus.dreq_strobe;
      wdata_q      <= dbus.dreq_wdata;
      misaligned_q <= misaligned_in;
    end
  end

  // Read one cycle ahead of RESP so the array maps to a synchronous RAM.
  // With LATENCY=1 the latched index is not yet valid, so read straight off the bus.
  assign rd_idx = (state_q == S_IDLE) ? dbus.dreq_addr[ADDR_BITS+1:2] : idx_q;

  assign resp_active = (state_q == S_RESP) && !reset;
  assign write_en    = resp_active && !misaligned_q;

  // Storage: registered read, byte-enabled write at the end of RESP.
  always_ff @(posedge clk) begin
    rd_q <= mem[rd_idx];
    for (int unsigned i = 0; i < 4; i++) begin
      if (write_en && strobe_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
    end
  end

  assign dbus.dresp_addr_ok = accept && !reset;
  assign dbus.dresp_data_ok = resp_active;
  assign dbus.dresp_err     = resp_active && misaligned_q;
  assign dbus.dresp_rdata   = (resp_active && !misaligned_q) ? rd_q : '0;

  // Saturating count of cycles the CPU is stalled on this port.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_wait <= '0;
    end else if (dbus.dreq_valid && !resp_active && (perf_wait != '1)) begin
      perf_wait <= perf_wait + 32'd1;
    end
  end

endmodule
